// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: runs an N-bit NOR/XOR/ADD/SUB through one external 1-bit ALU slice, LSB first.
// Optional signed-overflow output is enabled by defining ALU_SERIAL_SEQ_OVF_EN.
module alu_serial_seq #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         zero,
`ifdef ALU_SERIAL_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_cin,
    output logic [1:0]   alu_op,
    input  logic         alu_s,
    input  logic         alu_cout
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0]  OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  a_rem;
    logic [N-1:0]  b_rem;
    logic [N-1:0]  acc;
    logic [IW-1:0] idx;

    logic [N-1:0]  acc_next;
    logic          last_bit;
    logic          arith;

    // Result is assembled MSB-in so that bit 0 lands in position 0 after N shifts.
    assign acc_next = {alu_s, acc[N-1:1]};
    assign last_bit = (idx == IW'(N - 1));
    assign arith    = alu_op[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_rem   <= '0;
            b_rem   <= '0;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b1;
`ifdef ALU_SERIAL_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
            alu_a   <= 1'b0;
            alu_b   <= 1'b0;
            alu_cin <= 1'b0;
            alu_op  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Bit 0 is presented straight away; the rest is shifted out of a_rem/b_rem.
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        a_rem   <= a >> 1;
                        b_rem   <= b >> 1;
                        acc     <= '0;
                        idx     <= '0;
                        alu_a   <= a[0];
                        alu_b   <= b[0];
                        alu_op  <= op;
                        alu_cin <= (op == OP_SUB);
                    end
                end

                S_RUN: begin
                    acc <= acc_next;
                    if (last_bit) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        result  <= acc_next;
                        zero    <= (acc_next == '0);
                        cout    <= arith & alu_cout;
`ifdef ALU_SERIAL_SEQ_OVF_EN
                        ovf     <= arith & (alu_cin ^ alu_cout);
`endif
                        idx     <= '0;
                        alu_a   <= 1'b0;
                        alu_b   <= 1'b0;
                        alu_cin <= 1'b0;
                        alu_op  <= 2'b00;
                    end else begin
                        idx     <= idx + IW'(1);
                        alu_a   <= a_rem[0];
                        alu_b   <= b_rem[0];
                        alu_cin <= arith & alu_cout;
                        a_rem   <= a_rem >> 1;
                        b_rem   <= b_rem >> 1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (N=8) with a behavioural 1-bit ALU slice.
// Define ALU_SERIAL_SEQ_OVF_EN to also check the overflow output.
module tb_alu_serial_seq;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         zero;
`ifdef ALU_SERIAL_SEQ_OVF_EN
    logic         ovf;
`endif
    logic         alu_a;
    logic         alu_b;
    logic         alu_cin;
    logic [1:0]   alu_op;
    logic         alu_s;
    logic         alu_cout;

    int checks   = 0;
    int failures = 0;

    alu_serial_seq #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
`ifdef ALU_SERIAL_SEQ_OVF_EN
        .ovf      (ovf),
`endif
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_s    (alu_s),
        .alu_cout (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice
    always_comb begin
        logic bb;
        alu_s    = 1'b0;
        alu_cout = 1'b0;
        bb       = (alu_op == 2'b11) ? ~alu_b : alu_b;
        case (alu_op)
            2'b00: alu_s = ~(alu_a | alu_b);
            2'b01: alu_s = alu_a ^ alu_b;
            default: begin
                alu_s    = alu_a ^ bb ^ alu_cin;
                alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Waits for done after an accept edge; returns edges counted (20 on timeout).
    task automatic wait_done(output int n, input bit disturb, input logic [1:0] o,
                             input logic [7:0] x, input logic [7:0] y);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (disturb) begin
                start = (n == 3);
                op    = ~o;
                a     = (n[0]) ? ~x : 8'($urandom);
                b     = (n[0]) ? ~y : 8'($urandom);
            end
            if (done) break;
        end
        if (disturb) start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] er, input logic ec,
                          input logic ez, input logic eo, input bit disturb);
        int n;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_slice0"}, {28'd0, alu_op, alu_a, alu_b}, {28'd0, o, x[0], y[0]});
        check({tag, "_cin0"}, 32'(alu_cin), 32'(o == 2'b11));
        wait_done(n, disturb, o, x, y);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
`ifdef ALU_SERIAL_SEQ_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) check({tag, "_ovf_x"}, 32'(eo), 32'd0);
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_held"}, 32'(result), 32'(er));
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {30'd0, busy, done}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {30'd0, cout, zero}, 32'd1);
        check("rst_slice", {27'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_7f_01", 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_07", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_05_05", 2'b11, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("nor_f0_0f", 2'b00, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("xor_a5_ff", 2'b01, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("disturb", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

        // start held high through RUN and DONE
        op    = 2'b10;
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_latency", 32'(n), 32'd8);
        check("held_result1", 32'(result), 32'h03);
        a = 8'h10;
        b = 8'h20;
        @(posedge clk);
        #1;
        check("held_idle", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        check("held_accept", 32'(busy), 32'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_latency2", 32'(n), 32'd8);
        check("held_result2", 32'(result), 32'h30);
        @(posedge clk);
        #1;

        // Reset while bit 4 of an ADD is at the slice; start asserted with rst
        op    = 2'b10;
        a     = 8'h0F;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_cin", 32'(alu_cin), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("mid_rst_ctl", {30'd0, busy, done}, 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_flags", {30'd0, cout, zero}, 32'd1);
        check("mid_rst_slice", {27'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_start_dropped", 32'(busy), 32'd0);
        run_op("add_after_rst", 2'b10, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: next start raised in the IDLE cycle right after DONE
        run_op("b2b_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("b2b_00_00", 2'b10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
